// File: rtl/timer_counter_lap.sv
// Stopwatch/timer with min:sec:ms count, up/down mode, preset load and lap freeze.
// One command is acted on per edge (CLEAR > LOAD > STOP > START), otherwise LAP and tick.
module timer_counter_lap #(
  parameter int MS_MAX  = 999,
  parameter int SEC_MAX = 59,
  parameter int MIN_W   = 7,
  parameter int MIN_MAX = 99
) (
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_EN_1MS,
  input  logic             I_START_EN,
  input  logic             I_STOP_EN,
  input  logic             I_CLEAR_EN,
  input  logic             I_LAP_EN,
  input  logic             I_LOAD_EN,
  input  logic             I_MODE_DOWN,
  input  logic [9:0]       I_LOAD_MS,
  input  logic [5:0]       I_LOAD_SEC,
  input  logic [MIN_W-1:0] I_LOAD_MIN,
  output logic [9:0]       O_TIMER_MS,
  output logic [5:0]       O_TIMER_SEC,
  output logic [MIN_W-1:0] O_TIMER_MIN,
  output logic             O_RUN,
  output logic             O_LAP_HOLD,
  output logic             O_DONE
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [9:0]       MS_TOP  = 10'(MS_MAX);
  localparam logic [5:0]       SEC_TOP = 6'(SEC_MAX);
  localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MIN_MAX);
  localparam logic [MIN_W-1:0] MIN_ONE = MIN_W'(1);

  state_t           state_q, state_d;
  logic [9:0]       ms_q, ms_d, lap_ms_q, lap_ms_d, step_ms;
  logic [5:0]       sec_q, sec_d, lap_sec_q, lap_sec_d, step_sec;
  logic [MIN_W-1:0] min_q, min_d, lap_min_q, lap_min_d, step_min;
  logic             hold_q, hold_d;
  logic             at_max, at_zero, step_zero;

  assign at_max    = (ms_q == MS_TOP) && (sec_q == SEC_TOP) && (min_q == MIN_TOP);
  assign at_zero   = (ms_q == '0) && (sec_q == '0) && (min_q == '0);
  assign step_zero = (step_ms == '0) && (step_sec == '0) && (step_min == '0);

  // One tick's worth of movement with carry/borrow; ends of range are handled by the caller.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and give every output a default first,
    // so no path leaves a variable unassigned and no latch is inferred.
    step_ms  = ms_q;
    step_sec = sec_q;
    step_min = min_q;
    if (!I_MODE_DOWN) begin
      if (ms_q == MS_TOP) begin
        step_ms = '0;
        if (sec_q == SEC_TOP) begin
          step_sec = '0;
          step_min = min_q + MIN_ONE;
        end else begin
          step_sec = sec_q + 6'd1;
        end
      end else begin
        step_ms = ms_q + 10'd1;
      end
    end else begin
      if (ms_q == '0) begin
        step_ms = MS_TOP;
        if (sec_q == '0) begin
          step_sec = SEC_TOP;
          step_min = min_q - MIN_ONE;
        end else begin
          step_sec = sec_q - 6'd1;
        end
      end else begin
        step_ms = ms_q - 10'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ms_d      = ms_q;
    sec_d     = sec_q;
    min_d     = min_q;
    lap_ms_d  = lap_ms_q;
    lap_sec_d = lap_sec_q;
    lap_min_d = lap_min_q;
    hold_d    = hold_q;

    if (I_CLEAR_EN) begin
      ms_d    = '0;
      sec_d   = '0;
      min_d   = '0;
      hold_d  = 1'b0;
      state_d = IDLE;
    end else if (I_LOAD_EN) begin
      ms_d    = (I_LOAD_MS  > MS_TOP)  ? MS_TOP  : I_LOAD_MS;
      sec_d   = (I_LOAD_SEC > SEC_TOP) ? SEC_TOP : I_LOAD_SEC;
      min_d   = (I_LOAD_MIN > MIN_TOP) ? MIN_TOP : I_LOAD_MIN;
      hold_d  = 1'b0;
      state_d = IDLE;
    end else if (I_STOP_EN) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (I_START_EN) begin
      if (state_q == IDLE)       state_d = (I_MODE_DOWN && at_zero) ? DONE : RUN;
      else if (state_q == PAUSE) state_d = RUN;
    end else begin
      if ((state_q == RUN) && I_EN_1MS) begin
        if (I_MODE_DOWN ? at_zero : at_max) begin
          state_d = DONE;
        end else begin
          ms_d  = step_ms;
          sec_d = step_sec;
          min_d = step_min;
          if (I_MODE_DOWN && step_zero) state_d = DONE;
        end
      end
      // The lap snapshot takes the post-tick value so a coinciding tick is included.
      if (I_LAP_EN && ((state_q == RUN) || (state_q == PAUSE))) begin
        hold_d = !hold_q;
        if (!hold_q) begin
          lap_ms_d  = ms_d;
          lap_sec_d = sec_d;
          lap_min_d = min_d;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all registers update together on the edge.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q   <= IDLE;
      ms_q      <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      lap_ms_q  <= '0;
      lap_sec_q <= '0;
      lap_min_q <= '0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ms_q      <= ms_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      lap_ms_q  <= lap_ms_d;
      lap_sec_q <= lap_sec_d;
      lap_min_q <= lap_min_d;
      hold_q    <= hold_d;
    end
  end

  assign O_TIMER_MS  = hold_q ? lap_ms_q  : ms_q;
  assign O_TIMER_SEC = hold_q ? lap_sec_q : sec_q;
  assign O_TIMER_MIN = hold_q ? lap_min_q : min_q;
  assign O_RUN       = (state_q == RUN);
  assign O_DONE      = (state_q == DONE);
  assign O_LAP_HOLD  = hold_q;

endmodule
